// File: rtl/id_inst_queue_pkg.sv
// Shared constants and types for the IF-to-ID instruction queue.
// The packed {valid, pc, inst} bus replaces the old IF-to-ID bus at the ID input.
package id_inst_queue_pkg;

    localparam int IQ_DEPTH    = 4;
    localparam int IQ_PC_W     = 32;
    localparam int IQ_INST_W   = 32;
    localparam int IQ_TO_ID_WD = IQ_PC_W + IQ_INST_W + 1;

    typedef logic [IQ_TO_ID_WD-1:0] iq_to_id_bus_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'b00,
        OCC_PARTIAL = 2'b01,
        OCC_FULL    = 2'b10
    } occ_e;

    // Occupancy counter needs one extra bit so that "full" is distinguishable from "empty".
    function automatic int iq_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/id_inst_queue_if.sv
// Fetch-side push handshake, decode-side pop handshake and status of the instruction queue.
// The master modport is the queue itself; slave is the surrounding pipeline.
interface id_inst_queue_if
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int PC_W   = IQ_PC_W,
    parameter int INST_W = IQ_INST_W
);
    localparam int CNT_W    = iq_cnt_w(DEPTH);
    localparam int TO_ID_WD = PC_W + INST_W + 1;

    logic                flush;
    logic                in_valid;
    logic [PC_W-1:0]     in_pc;
    logic [INST_W-1:0]   in_inst;
    logic                in_ready;
    logic                out_valid;
    logic [PC_W-1:0]     out_pc;
    logic [INST_W-1:0]   out_inst;
    logic                out_ready;
    logic                stallreq;
    logic [CNT_W-1:0]    count;
    logic [TO_ID_WD-1:0] to_id_bus;

    modport master (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, stallreq, count, to_id_bus
    );

    modport slave (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, stallreq, count, to_id_bus
    );

endinterface

// File: rtl/id_inst_queue_ptr_ctrl.sv
// Head/tail pointers and occupancy count of the instruction queue.
// Pointers wrap by natural overflow, so DEPTH must be a power of two.
module iq_ptr_ctrl
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [CNT_W-1:0] count,
    output occ_e             occ
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Pointer and count update; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Occupancy classification from the registered count only.
    always_comb begin
        occ = OCC_PARTIAL;
        if (count_r == {CNT_W{1'b0}}) begin
            occ = OCC_EMPTY;
        end else if (count_r == DEPTH_CNT) begin
            occ = OCC_FULL;
        end else begin
            occ = OCC_PARTIAL;
        end
    end

    assign rd_ptr = rd_ptr_r;
    assign wr_ptr = wr_ptr_r;
    assign count  = count_r;

endmodule

// File: rtl/id_inst_queue.sv
// DEPTH-entry circular FIFO of {pc, inst} between IF and ID, with flush and optional
// zero-latency bypass when empty. in_ready depends only on state, never on out_ready.
module id_inst_queue
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int PC_W   = IQ_PC_W,
    parameter int INST_W = IQ_INST_W,
    parameter int BYPASS = 0
) (
    input  logic           clk,
    input  logic           rst,
    id_inst_queue_if.master iq
);

    localparam int   PTR_W   = $clog2(DEPTH);
    localparam int   CNT_W   = PTR_W + 1;
    localparam int   ENTRY_W = PC_W + INST_W;
    localparam logic BYP_EN  = 1'(BYPASS);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_s;
    logic [PTR_W-1:0]   wr_ptr_s;
    logic [CNT_W-1:0]   count_s;
    occ_e               occ_s;
    logic               empty_s;
    logic               full_s;
    logic               bypass_take_s;
    logic               push_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] head_s;
    logic               out_valid_s;
    logic [PC_W-1:0]    out_pc_s;
    logic [INST_W-1:0]  out_inst_s;

    assign empty_s = (occ_s == OCC_EMPTY);
    assign full_s  = (occ_s == OCC_FULL);
    assign head_s  = mem_r[rd_ptr_s];

    // Handshake decode; a bypassed instruction is consumed directly and never stored.
    always_comb begin
        bypass_take_s = BYP_EN & empty_s & iq.in_valid & iq.out_ready & ~iq.flush;
        push_s        = iq.in_valid & ~full_s & ~bypass_take_s;
        pop_s         = iq.out_ready & ~empty_s;
    end

    iq_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk    (clk),
        .rst    (rst),
        .flush  (iq.flush),
        .push   (push_s),
        .pop    (pop_s),
        .rd_ptr (rd_ptr_s),
        .wr_ptr (wr_ptr_s),
        .count  (count_s),
        .occ    (occ_s)
    );

    // Entry storage; stale contents after a flush are harmless because count is zero.
    always_ff @(posedge clk) begin
        if (push_s && !iq.flush) begin
            mem_r[wr_ptr_s] <= {iq.in_pc, iq.in_inst};
        end
    end

    // Head / bypass mux; an invalid head always presents pc 0 and a nop.
    always_comb begin
        out_valid_s = 1'b0;
        out_pc_s    = {PC_W{1'b0}};
        out_inst_s  = {INST_W{1'b0}};
        if (BYP_EN && iq.flush) begin
            out_valid_s = 1'b0;
        end else if (!empty_s) begin
            out_valid_s = 1'b1;
            out_pc_s    = head_s[ENTRY_W-1:INST_W];
            out_inst_s  = head_s[INST_W-1:0];
        end else if (BYP_EN && iq.in_valid) begin
            out_valid_s = 1'b1;
            out_pc_s    = iq.in_pc;
            out_inst_s  = iq.in_inst;
        end else begin
            out_valid_s = 1'b0;
        end
    end

    assign iq.in_ready  = ~full_s;
    assign iq.stallreq  = full_s;
    assign iq.count     = count_s;
    assign iq.out_valid = out_valid_s;
    assign iq.out_pc    = out_pc_s;
    assign iq.out_inst  = out_inst_s;
    assign iq.to_id_bus = {out_valid_s, out_pc_s, out_inst_s};

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue: one instance without bypass, one with bypass.
module tb_id_inst_queue;
    import id_inst_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_inst_queue_if #(.DEPTH(4), .PC_W(32), .INST_W(32)) a_if ();
    id_inst_queue_if #(.DEPTH(4), .PC_W(32), .INST_W(32)) b_if ();

    id_inst_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .BYPASS(0)) dut_a (
        .clk (clk), .rst (rst), .iq (a_if.master)
    );
    id_inst_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .BYPASS(1)) dut_b (
        .clk (clk), .rst (rst), .iq (b_if.master)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic drive_a(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        a_if.in_valid  = v;
        a_if.in_pc     = pc;
        a_if.in_inst   = inst_of(pc);
        a_if.out_ready = rdy;
        a_if.flush     = fl;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        b_if.in_valid  = v;
        b_if.in_pc     = pc;
        b_if.in_inst   = inst_of(pc);
        b_if.out_ready = rdy;
        b_if.flush     = fl;
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] next_pc;
    logic        m_ready;

    // Compare DUT A against the queue model, then advance the model by one edge.
    task automatic model_cycle(input string tag);
        m_ready = (exp_q.size() != 4);
        #3;
        check_eq({tag, "_in_ready"}, a_if.in_ready, m_ready);
        check_eq({tag, "_out_valid"}, a_if.out_valid, exp_q.size() != 0);
        check_eq({tag, "_out_pc"}, a_if.out_pc, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
        check_eq({tag, "_count"}, a_if.count, exp_q.size());
        tick();
        if (a_if.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (a_if.in_valid && m_ready) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'h4;
            a_if.in_pc   = next_pc;
            a_if.in_inst = inst_of(next_pc);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        drive_b(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        check_eq("rst_in_ready", a_if.in_ready, 1'b1);
        check_eq("rst_stallreq", a_if.stallreq, 1'b0);
        check_eq("rst_out_valid", a_if.out_valid, 1'b0);
        check_eq("rst_out_pc", a_if.out_pc, 32'h0);
        check_eq("rst_out_inst", a_if.out_inst, 32'h0);
        check_eq("rst_count", a_if.count, 3'd0);
        check_eq("rst_b_out_valid", b_if.out_valid, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Three pushes while ID stalls, then drain in order.
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 32'hBFC0_0000 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive_a(1'b0, 32'h0, 1'b1, 1'b0);
        #3;
        check_eq("t1_count", a_if.count, 3'd3);
        check_eq("t1_in_ready", a_if.in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_eq("t1_pop_pc", a_if.out_pc, 32'hBFC0_0000 + 32'(4 * i));
            check_eq("t1_pop_inst", a_if.out_inst, inst_of(32'hBFC0_0000 + 32'(4 * i)));
            tick();
            #3;
        end
        check_eq("t1_empty_valid", a_if.out_valid, 1'b0);
        check_eq("t1_empty_inst", a_if.out_inst, 32'h0);
        check_eq("t1_empty_bus", a_if.to_id_bus, 65'h0);

        // Five pushes into a depth-4 queue; the fifth must be refused.
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
            #3;
            if (i == 3) check_eq("t2_ready_before_4th", a_if.in_ready, 1'b1);
            if (i == 4) begin
                check_eq("t2_full_in_ready", a_if.in_ready, 1'b0);
                check_eq("t2_full_stallreq", a_if.stallreq, 1'b1);
                check_eq("t2_full_count", a_if.count, 3'd4);
            end
            tick();
        end
        #3;
        check_eq("t2_count_after_5th", a_if.count, 3'd4);
        check_eq("t2_head_bus", a_if.to_id_bus, {1'b1, 32'h1000, inst_of(32'h1000)});

        // Full queue with push and pop requested every cycle, then drain.
        exp_q   = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        next_pc = 32'h2000;
        drive_a(1'b1, next_pc, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) model_cycle("t3");
        a_if.in_valid = 1'b0;
        for (int c = 0; c < 5; c++) model_cycle("t3_drain");

        // Flush with a concurrent push and pop at count=2.
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive_a(1'b1, 32'h3008, 1'b1, 1'b1);
        tick();
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        check_eq("t4_flush_count", a_if.count, 3'd0);
        check_eq("t4_flush_valid", a_if.out_valid, 1'b0);
        tick();
        #3;
        check_eq("t4_flush_still_empty", a_if.out_valid, 1'b0);
        drive_a(1'b1, 32'h300C, 1'b0, 1'b0);
        tick();
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        check_eq("t4_post_flush_pc", a_if.out_pc, 32'h300C);
        check_eq("t4_post_flush_count", a_if.count, 3'd1);
        a_if.out_ready = 1'b1;
        tick();
        a_if.out_ready = 1'b0;

        // Asynchronous reset between clock edges with three entries held.
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check_eq("t6_count_before_rst", a_if.count, 3'd3);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t6_async_count", a_if.count, 3'd0);
        check_eq("t6_async_valid", a_if.out_valid, 1'b0);
        check_eq("t6_async_pc", a_if.out_pc, 32'h0);
        #2;
        rst = 1'b0;
        tick();

        // Bypass instance: same-cycle pass-through, stalled bypass, flush masking.
        drive_b(1'b1, 32'h100, 1'b1, 1'b0);
        #3;
        check_eq("t5_byp_valid", b_if.out_valid, 1'b1);
        check_eq("t5_byp_pc", b_if.out_pc, 32'h100);
        check_eq("t5_byp_inst", b_if.out_inst, inst_of(32'h100));
        tick();
        drive_b(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        check_eq("t5_byp_count", b_if.count, 3'd0);
        check_eq("t5_byp_no_dup", b_if.out_valid, 1'b0);
        drive_b(1'b1, 32'h104, 1'b0, 1'b0);
        #3;
        check_eq("t5_stall_valid", b_if.out_valid, 1'b1);
        check_eq("t5_stall_pc", b_if.out_pc, 32'h104);
        tick();
        drive_b(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        check_eq("t5_stored_count", b_if.count, 3'd1);
        check_eq("t5_stored_pc", b_if.out_pc, 32'h104);
        drive_b(1'b1, 32'h108, 1'b1, 1'b1);
        #3;
        check_eq("t5_flush_mask", b_if.out_valid, 1'b0);
        tick();
        drive_b(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        check_eq("t5_flush_count", b_if.count, 3'd0);
        check_eq("t5_flush_valid", b_if.out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
